// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/redirect control slice.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    REDIR = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [4:0]  REG_ZERO    = 5'd0;
  localparam logic [31:0] NO_REDIRECT = 32'h0000_0000;
  localparam logic [31:0] RESET_PC    = 32'h0040_0000;

  // True when an ID source operand really reads the register EX is about to write.
  function automatic logic src_match(input logic uses, input logic [4:0] src, input logic [4:0] rd);
    return uses & (src == rd);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Stall / redirect performance counters, both free-running 32-bit wrap counters.
// Only present when HAZARD_PERF_EN is defined.
`ifdef HAZARD_PERF_EN
module hazard_perf_cnt
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_inc,
  input  logic        flush_inc,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  logic [31:0] stall_count_r;
  logic [31:0] flush_count_r;

  // Counter registers; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_r <= 32'd0;
      flush_count_r <= 32'd0;
    end else begin
      if (stall_inc) begin
        stall_count_r <= stall_count_r + 32'd1;
      end else begin
        stall_count_r <= stall_count_r;
      end
      if (flush_inc) begin
        flush_count_r <= flush_count_r + 32'd1;
      end else begin
        flush_count_r <= flush_count_r;
      end
    end
  end

  assign stall_count = stall_count_r;
  assign flush_count = flush_count_r;

endmodule
`endif

// File: rtl/hazard_redirect_unit_chk.sv
// Protocol checker for hazard_redirect_unit: illegal EX-stage combinations.
module hazard_redirect_unit_chk #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_use,
  input  logic            ex_branch_taken,
  input  logic            take,
  input  logic [XLEN-1:0] ex_branch_target
);

  // A load is never a branch, so a load-use hazard cannot coincide with a taken branch.
  a_load_not_branch : assert property (@(posedge clk) disable iff (reset)
    !(load_use && ex_branch_taken));

  // Target 0 is reserved to mean "no redirect" and must never be taken.
  a_target_nonzero : assert property (@(posedge clk) disable iff (reset)
    take |-> (ex_branch_target != {XLEN{1'b0}}));

endmodule

// File: rtl/hazard_redirect_unit.sv
// Fetch-redirect and hazard control: load-use / memory-busy stalls, branch redirect pulse, flush.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_redirect_unit
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int SQUASH_DEPTH = 2,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic            ex_valid,
  input  logic [4:0]      ex_rd,
  input  logic            ex_mem_read,
  input  logic            ex_branch_taken,
  input  logic [XLEN-1:0] ex_branch_target,
  input  logic            mem_busy,
  output logic [XLEN-1:0] branch_PC,
  output logic            stall,
  output logic            flush,
  output logic            id_ex_bubble,
  output logic [31:0]     stall_count,
  output logic [31:0]     flush_count
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int SQ_W = (SQUASH_DEPTH > 0) ? $clog2(SQUASH_DEPTH + 1) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(SQUASH_DEPTH);
  localparam logic [XLEN-1:0] PC_NONE = XLEN'(NO_REDIRECT);

  logic            load_use_s;
  logic            stall_s;
  logic            take_s;
  state_t          state_r, state_n_s;
  logic [XLEN-1:0] branch_pc_r, branch_pc_n_s;
  logic            flush_r, flush_n_s;
  logic [FC_W-1:0] flush_cnt_r, flush_cnt_n_s;
  logic [SQ_W-1:0] squash_cnt_r, squash_cnt_n_s;

  // Hazard detection and redirect qualification.
  always_comb begin
    load_use_s = ex_valid & ex_mem_read & (ex_rd != REG_ZERO) &
                 (src_match(id_uses_rs1, id_rs1, ex_rd) | src_match(id_uses_rs2, id_rs2, ex_rd));
    stall_s    = mem_busy | load_use_s;
    // A frozen pipeline must not redirect; the branch is re-seen once the stall clears.
    take_s     = (state_r == RUN) & ex_valid & ex_branch_taken & ~stall_s &
                 (squash_cnt_r == {SQ_W{1'b0}});
  end

  assign stall        = stall_s;
  assign id_ex_bubble = load_use_s & ~mem_busy;

  // Redirect FSM next-state and next registered outputs.
  always_comb begin
    state_n_s     = state_r;
    branch_pc_n_s = PC_NONE;
    flush_n_s     = 1'b0;
    flush_cnt_n_s = flush_cnt_r;
    case (state_r)
      RUN: begin
        if (take_s) begin
          state_n_s     = REDIR;
          branch_pc_n_s = ex_branch_target;
          flush_n_s     = 1'b1;
          flush_cnt_n_s = FC_LOAD;
        end else begin
          state_n_s     = RUN;
        end
      end
      REDIR: begin
        if (flush_cnt_r != {FC_W{1'b0}}) begin
          state_n_s     = FLUSH;
          flush_n_s     = 1'b1;
          flush_cnt_n_s = flush_cnt_r - {{(FC_W-1){1'b0}}, 1'b1};
        end else begin
          state_n_s     = RUN;
        end
      end
      FLUSH: begin
        if (flush_cnt_r != {FC_W{1'b0}}) begin
          state_n_s     = FLUSH;
          flush_n_s     = 1'b1;
          flush_cnt_n_s = flush_cnt_r - {{(FC_W-1){1'b0}}, 1'b1};
        end else begin
          state_n_s     = RUN;
        end
      end
      default: begin
        state_n_s     = RUN;
        flush_cnt_n_s = {FC_W{1'b0}};
      end
    endcase
  end

  // Wrong-path window: ignores branches for SQUASH_DEPTH advancing cycles after a redirect.
  always_comb begin
    if (take_s) begin
      squash_cnt_n_s = SQ_LOAD;
    end else if ((squash_cnt_r != {SQ_W{1'b0}}) && !stall_s) begin
      squash_cnt_n_s = squash_cnt_r - {{(SQ_W-1){1'b0}}, 1'b1};
    end else begin
      squash_cnt_n_s = squash_cnt_r;
    end
  end

  // State and output registers; reset drops any pending redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= RUN;
      branch_pc_r  <= PC_NONE;
      flush_r      <= 1'b0;
      flush_cnt_r  <= {FC_W{1'b0}};
      squash_cnt_r <= {SQ_W{1'b0}};
    end else begin
      state_r      <= state_n_s;
      branch_pc_r  <= branch_pc_n_s;
      flush_r      <= flush_n_s;
      flush_cnt_r  <= flush_cnt_n_s;
      squash_cnt_r <= squash_cnt_n_s;
    end
  end

  assign branch_PC = branch_pc_r;
  assign flush     = flush_r;

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt u_perf (
    .clk         (clk),
    .reset       (reset),
    .stall_inc   (stall_s),
    .flush_inc   (take_s),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );
`else
  assign stall_count = 32'd0;
  assign flush_count = 32'd0;
`endif

  hazard_redirect_unit_chk #(.XLEN(XLEN)) u_chk (
    .clk              (clk),
    .reset            (reset),
    .load_use         (load_use_s),
    .ex_branch_taken  (ex_branch_taken),
    .take             (take_s),
    .ex_branch_target (ex_branch_target)
  );

endmodule
